// File: rtl/byte_ram_pkg.sv
// Shared sizing, lane type and FSM state encoding for the byte-combining RAM writer.
package byte_ram_pkg;

    localparam int unsigned SIZE  = 65536;
    localparam int unsigned ADDRW = $clog2(SIZE / 4);

    typedef logic [1:0] lane_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [3:0] lane_onehot(input lane_t lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/ram_be32.sv
// 32-bit word RAM with per-byte write enables and a registered, reset-clearable read port.
module ram_be32 #(
    parameter int unsigned AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic          rd_valid
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_d, rd_data_q;
    logic        rd_valid_q;

    // Storage is never reset so that a reset keeps previously committed words.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/byte_ram_writer.sv
// Byte-write front end: combines byte writes into one word buffer and commits it
// to ram_be32 with a byte-enable mask on word change, full mask, or flush.
module byte_ram_writer #(
    parameter int unsigned SIZE  = 65536,
    parameter int unsigned ADDRW = $clog2(SIZE / 4)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_addr,
    input  logic [7:0]       in_data,
    input  logic             flush,
    input  logic             rd_en,
    input  logic [ADDRW-1:0] rd_addr,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic             oor,
    output logic [15:0]      oor_count,
    output logic             busy
);

    import byte_ram_pkg::*;

    state_t           state_d, state_q;
    logic [ADDRW-1:0] waddr_d, waddr_q;
    logic [31:0]      data_d, data_q;
    logic [3:0]       be_d, be_q;
    logic             oor_d, oor_q;
    logic [15:0]      oor_cnt_d, oor_cnt_q;

    logic             accept, out_of_range, acc_ok, full, miss, wr_en;
    lane_t            in_lane;
    logic [ADDRW-1:0] in_waddr;

    assign in_ready     = (state_q != DRAIN);
    assign busy         = (state_q != EMPTY);
    assign accept       = in_valid && in_ready;
    assign out_of_range = |(in_addr >> (ADDRW + 2));
    assign acc_ok       = accept && !out_of_range;
    assign in_lane      = in_addr[1:0];
    assign in_waddr     = in_addr[ADDRW+1:2];
    assign full         = (be_q == 4'hF);
    assign miss         = (in_waddr != waddr_q);

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        data_d  = data_q;
        be_d    = be_q;
        wr_en   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (acc_ok) begin
                    waddr_d                       = in_waddr;
                    data_d[8*int'(in_lane) +: 8]  = in_data;
                    be_d                          = lane_onehot(in_lane);
                    state_d                       = flush ? DRAIN : FILL;
                end
            end
            FILL: begin
                // A full mask or a different word commits the old buffer this
                // cycle; an accepted byte then starts a fresh buffer without stalling.
                wr_en = full || (acc_ok && miss);
                if (acc_ok) begin
                    waddr_d                       = in_waddr;
                    data_d[8*int'(in_lane) +: 8]  = in_data;
                    be_d                          = (full || miss) ? lane_onehot(in_lane)
                                                                   : (be_q | lane_onehot(in_lane));
                    state_d                       = flush ? DRAIN : FILL;
                end else if (full) begin
                    be_d    = '0;
                    state_d = EMPTY;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                wr_en   = 1'b1;
                be_d    = '0;
                state_d = EMPTY;
            end
            default: begin
                be_d    = '0;
                state_d = EMPTY;
            end
        endcase
    end

    always_comb begin
        oor_d     = accept && out_of_range;
        oor_cnt_d = oor_cnt_q;
        if (oor_d && (oor_cnt_q != 16'hFFFF)) begin
            oor_cnt_d = oor_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            waddr_q   <= '0;
            data_q    <= '0;
            be_q      <= '0;
            oor_q     <= 1'b0;
            oor_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            data_q    <= data_d;
            be_q      <= be_d;
            oor_q     <= oor_d;
            oor_cnt_q <= oor_cnt_d;
        end
    end

    assign oor       = oor_q;
    assign oor_count = oor_cnt_q;

    ram_be32 #(
        .AW(ADDRW)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_en),
        .be       (be_q),
        .wr_addr  (waddr_q),
        .wr_data  (data_q),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule

// File: tb/tb_byte_ram_writer.sv
// Scoreboard bench for byte_ram_writer: expected read words are queued when a read
// is issued and compared when rd_valid returns.
module tb_byte_ram_writer;

    localparam int unsigned ADDRW = 14;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_addr = '0;
    logic [7:0]       in_data = '0;
    logic             flush = 1'b0;
    logic             rd_en = 1'b0;
    logic [ADDRW-1:0] rd_addr = '0;
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             oor;
    logic [15:0]      oor_count;
    logic             busy;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] sb_q [$];

    byte_ram_writer #(
        .SIZE (65536),
        .ADDRW(ADDRW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .flush    (flush),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .oor      (oor),
        .oor_count(oor_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                check("rd_data", rd_data, sb_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [31:0] a, input logic [7:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic rd_word(input int unsigned w, input logic [31:0] exp);
        rd_en   = 1'b1;
        rd_addr = ADDRW'(w);
        sb_q.push_back(exp);
        step();
        rd_en = 1'b0;
    endtask

    task automatic preload(input int unsigned w, input logic [31:0] val);
        for (int unsigned i = 0; i < 4; i++) begin
            wr_byte(32'(w * 4 + i), val[8*i +: 8]);
        end
        step();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_oor", 32'(oor), 32'd0);
        check("rst_oor_count", 32'(oor_count), 32'd0);
        rst = 1'b0;
        step();

        // four lanes of word 0, auto-commit on full mask
        wr_byte(32'd0, 8'h01);
        wr_byte(32'd1, 8'h02);
        wr_byte(32'd2, 8'h03);
        wr_byte(32'd3, 8'h04);
        check("full_busy", 32'(busy), 32'd1);
        step();
        check("autocommit_busy", 32'(busy), 32'd0);
        rd_word(0, 32'h04030201);
        step();
        check("rd_hold_valid", 32'(rd_valid), 32'd0);
        check("rd_hold_data", rd_data, 32'h04030201);

        // partial lane with flush; in_ready low only during DRAIN
        preload(1, 32'hDEADBEEF);
        wr_byte(32'd5, 8'hAA);
        check("fill_in_ready", 32'(in_ready), 32'd1);
        do_flush();
        check("drain_in_ready", 32'(in_ready), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        step();
        check("post_drain_in_ready", 32'(in_ready), 32'd1);
        check("post_drain_busy", 32'(busy), 32'd0);
        rd_word(1, 32'hDEADAAEF);

        // word change commits old buffer without stall; no forwarding on read
        preload(2, 32'hCAFEF00D);
        preload(3, 32'h12345678);
        wr_byte(32'd8, 8'h11);
        in_valid = 1'b1;
        in_addr  = 32'd12;
        in_data  = 8'h22;
        check("miss_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("miss_busy", 32'(busy), 32'd1);
        rd_word(2, 32'hCAFEF011);
        rd_word(3, 32'h12345678);
        do_flush();
        step();
        rd_word(3, 32'h12345622);

        // out-of-range write dropped, pulse and counter
        wr_byte(32'h0001_0000, 8'h99);
        check("oor_pulse", 32'(oor), 32'd1);
        check("oor_count_1", 32'(oor_count), 32'd1);
        check("oor_busy", 32'(busy), 32'd0);
        step();
        check("oor_pulse_end", 32'(oor), 32'd0);
        rd_word(0, 32'h04030201);
        in_valid = 1'b1;
        in_addr  = 32'h0001_0000;
        in_data  = 8'h5A;
        for (int unsigned i = 0; i < 65536; i++) begin
            step();
        end
        in_valid = 1'b0;
        step();
        check("oor_count_sat", 32'(oor_count), 32'h0000FFFF);

        // repeated lane keeps newest byte
        wr_byte(32'd0, 8'h10);
        wr_byte(32'd0, 8'h20);
        do_flush();
        step();
        rd_word(0, 32'h04030220);

        // reset discards buffered byte and restores all outputs
        wr_byte(32'd2, 8'h55);
        rst = 1'b1;
        #1;
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_in_ready", 32'(in_ready), 32'd1);
        check("rst2_rd_data", rd_data, 32'd0);
        check("rst2_rd_valid", 32'(rd_valid), 32'd0);
        check("rst2_oor_count", 32'(oor_count), 32'd0);
        check("rst2_oor", 32'(oor), 32'd0);
        step();
        rst = 1'b0;
        step();
        rd_word(0, 32'h04030220);

        // reset during DRAIN aborts the commit
        wr_byte(32'd1, 8'h77);
        do_flush();
        check("abort_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        rd_word(0, 32'h04030220);

        step();
        step();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
